i2c_cmd_sequencer: RTL

- Command front end that sits directly upstream of the I2C master controller.
- Accepts queued I2C transactions from system logic, issues them one at a time to the master over the enable/ready handshake, and returns a one-cycle response per transaction.
- A response carries read data and a timeout flag.
- Replaces ad-hoc toggling of the master enable from the readiness signal.

---
 rtl/i2c_cmd_sequencer_if.sv | 38 +++
 rtl/i2c_cmd_sequencer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/i2c_cmd_sequencer_if.sv
// Signal bundle between system logic, i2c_cmd_sequencer and the I2C master.
// slave is the sequencer's view; master is the view of the logic driving it.
interface i2c_cmd_sequencer_if #(
    parameter int unsigned FIFO_DEPTH = 4
);
    localparam int unsigned CNT_FW = $clog2(FIFO_DEPTH) + 1;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [6:0]        cmd_addr;
    logic              cmd_rw;
    logic [7:0]        cmd_data;
    logic              rsp_valid;
    logic              rsp_rw;
    logic [6:0]        rsp_addr;
    logic [7:0]        rsp_data;
    logic              rsp_timeout;
    logic              mst_enable;
    logic [6:0]        mst_addr;
    logic              mst_rw;
    logic [7:0]        mst_data_in;
    logic [7:0]        mst_data_out;
    logic              mst_ready;
    logic              busy;
    logic [CNT_FW-1:0] fifo_count;

    modport slave (
        input  cmd_valid, cmd_addr, cmd_rw, cmd_data, mst_data_out, mst_ready,
        output cmd_ready, rsp_valid, rsp_rw, rsp_addr, rsp_data, rsp_timeout,
               mst_enable, mst_addr, mst_rw, mst_data_in, busy, fifo_count
    );

    modport master (
        output cmd_valid, cmd_addr, cmd_rw, cmd_data, mst_data_out, mst_ready,
        input  cmd_ready, rsp_valid, rsp_rw, rsp_addr, rsp_data, rsp_timeout,
               mst_enable, mst_addr, mst_rw, mst_data_in, busy, fifo_count
    );
endinterface

// File: rtl/i2c_cmd_sequencer.sv
// Queues I2C commands and issues them one at a time to the master over the
// enable/ready handshake, returning a one-cycle response per command.
module i2c_cmd_sequencer #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned CNT_W          = 17
) (
    input logic                clk,
    input logic                rst,
    i2c_cmd_sequencer_if.slave bus
);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_FW = PTR_W + 1;
    localparam int unsigned ENT_W  = 16;

    typedef enum logic [1:0] {IDLE, LAUNCH, RUN, RESP} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  tmo_q, tmo_d;
    logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_FW-1:0] count_q, count_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              busy_q, busy_d;
    logic              mst_enable_q, mst_enable_d;
    logic [6:0]        mst_addr_q, mst_addr_d;
    logic              mst_rw_q, mst_rw_d;
    logic [7:0]        mst_data_q, mst_data_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_rw_q, rsp_rw_d;
    logic [6:0]        rsp_addr_q, rsp_addr_d;
    logic [7:0]        rsp_data_q, rsp_data_d;
    logic              rsp_timeout_q, rsp_timeout_d;

    logic              push_c, pop_c, tmo_hit_c, done_c, to_c;
    logic [ENT_W-1:0]  head_c;

    assign push_c    = bus.cmd_valid && cmd_ready_q;
    assign pop_c     = (state_q == IDLE) && (count_q != '0) && bus.mst_ready;
    assign tmo_hit_c = (tmo_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign head_c    = mem_q[rd_ptr_q];

    // Queue bookkeeping; a push at full is already blocked by cmd_ready.
    always_comb begin
        wr_ptr_d    = wr_ptr_q + PTR_W'(push_c);
        rd_ptr_d    = rd_ptr_q + PTR_W'(pop_c);
        count_d     = count_q + CNT_FW'(push_c) - CNT_FW'(pop_c);
        cmd_ready_d = (count_d < CNT_FW'(FIFO_DEPTH));
    end

    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= {bus.cmd_addr, bus.cmd_rw, bus.cmd_data};
        end
    end

    always_comb begin
        state_d       = state_q;
        tmo_d         = tmo_q + CNT_W'(1);
        mst_enable_d  = mst_enable_q;
        mst_addr_d    = mst_addr_q;
        mst_rw_d      = mst_rw_q;
        mst_data_d    = mst_data_q;
        rsp_valid_d   = 1'b0;
        rsp_rw_d      = rsp_rw_q;
        rsp_addr_d    = rsp_addr_q;
        rsp_data_d    = rsp_data_q;
        rsp_timeout_d = rsp_timeout_q;
        done_c        = 1'b0;
        to_c          = 1'b0;

        case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (pop_c) begin
                    state_d      = LAUNCH;
                    mst_enable_d = 1'b1;
                    mst_addr_d   = head_c[15:9];
                    mst_rw_d     = head_c[8];
                    mst_data_d   = head_c[7:0];
                end
            end
            LAUNCH: begin
                if (!bus.mst_ready) begin
                    state_d      = RUN;
                    mst_enable_d = 1'b0;
                    tmo_d        = '0;
                end else if (tmo_hit_c) begin
                    done_c = 1'b1;
                    to_c   = 1'b1;
                end
            end
            RUN: begin
                if (bus.mst_ready) begin
                    done_c = 1'b1;
                end else if (tmo_hit_c) begin
                    done_c = 1'b1;
                    to_c   = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
                tmo_d   = '0;
            end
            default: state_d = IDLE;
        endcase

        // Completion (normal or aborted) always passes through RESP.
        if (done_c) begin
            state_d       = RESP;
            tmo_d         = '0;
            mst_enable_d  = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_rw_d      = mst_rw_q;
            rsp_addr_d    = mst_addr_q;
            rsp_timeout_d = to_c;
            rsp_data_d    = (!to_c && mst_rw_q) ? bus.mst_data_out : 8'h00;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            tmo_q         <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            cmd_ready_q   <= 1'b0;
            busy_q        <= 1'b0;
            mst_enable_q  <= 1'b0;
            mst_addr_q    <= '0;
            mst_rw_q      <= 1'b0;
            mst_data_q    <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rw_q      <= 1'b0;
            rsp_addr_q    <= '0;
            rsp_data_q    <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            tmo_q         <= tmo_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            cmd_ready_q   <= cmd_ready_d;
            busy_q        <= busy_d;
            mst_enable_q  <= mst_enable_d;
            mst_addr_q    <= mst_addr_d;
            mst_rw_q      <= mst_rw_d;
            mst_data_q    <= mst_data_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rw_q      <= rsp_rw_d;
            rsp_addr_q    <= rsp_addr_d;
            rsp_data_q    <= rsp_data_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.busy        = busy_q;
    assign bus.fifo_count  = count_q;
    assign bus.mst_enable  = mst_enable_q;
    assign bus.mst_addr    = mst_addr_q;
    assign bus.mst_rw      = mst_rw_q;
    assign bus.mst_data_in = mst_data_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rw      = rsp_rw_q;
    assign bus.rsp_addr    = rsp_addr_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_timeout = rsp_timeout_q;
endmodule
